// File: rtl/cpu_cache_pkg.sv
// Shared constants, types and address helpers for the cpu_cache slice.
// The optional statistics counters are enabled with the CPU_CACHE_STATS_EN macro.
package cpu_cache_pkg;

  localparam int CACHE_ADDR_WIDTH = 32;
  localparam int CACHE_WORD_WIDTH = 32;
  localparam int CACHE_LINE_WIDTH = 128;
  localparam int CACHE_NUM_LINES  = 4;

  localparam int WORDS_PER_LINE = CACHE_LINE_WIDTH / CACHE_WORD_WIDTH;
  localparam int OFFSET_BITS    = $clog2(CACHE_LINE_WIDTH / 8);
  localparam int WORD_SEL_BITS  = $clog2(WORDS_PER_LINE);
  localparam int INDEX_BITS     = $clog2(CACHE_NUM_LINES);
  localparam int TAG_BITS       = CACHE_ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_FILL      = 2'd2
  } cache_state_t;

  typedef struct packed {
    logic                        valid;
    logic                        dirty;
    logic [TAG_BITS-1:0]         tag;
    logic [CACHE_LINE_WIDTH-1:0] data;
  } cache_line_t;

  function automatic logic [INDEX_BITS-1:0] addr_index(input logic [CACHE_ADDR_WIDTH-1:0] addr);
    return addr[OFFSET_BITS +: INDEX_BITS];
  endfunction

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [CACHE_ADDR_WIDTH-1:0] addr);
    return addr[CACHE_ADDR_WIDTH-1 -: TAG_BITS];
  endfunction

  // Word select sits just below the line offset; the byte bits are don't-care.
  function automatic logic [WORD_SEL_BITS-1:0] addr_word(input logic [CACHE_ADDR_WIDTH-1:0] addr);
    return addr[OFFSET_BITS-1 -: WORD_SEL_BITS];
  endfunction

  function automatic logic [CACHE_ADDR_WIDTH-1:0] line_addr(input logic [TAG_BITS-1:0]   tag,
                                                            input logic [INDEX_BITS-1:0] index);
    return {tag, index, {OFFSET_BITS{1'b0}}};
  endfunction

  function automatic logic [CACHE_WORD_WIDTH-1:0] line_word(input logic [CACHE_LINE_WIDTH-1:0] line,
                                                            input logic [WORD_SEL_BITS-1:0]   sel);
    return line[CACHE_WORD_WIDTH*sel +: CACHE_WORD_WIDTH];
  endfunction

endpackage

// File: rtl/cpu_cache_if.sv
// CPU-side and memory-side request/response interfaces of cpu_cache.
interface cpu_cache_request_if;
  import cpu_cache_pkg::*;
  logic                        read;
  logic                        write;
  logic [CACHE_ADDR_WIDTH-1:0] addr;
  logic [CACHE_WORD_WIDTH-1:0] data;
  modport master (output read, write, addr, data);
  modport slave  (input  read, write, addr, data);
endinterface

interface cpu_cache_response_if;
  import cpu_cache_pkg::*;
  logic                        valid;
  logic [CACHE_WORD_WIDTH-1:0] data;
  modport master (output valid, data);
  modport slave  (input  valid, data);
endinterface

interface cpu_cache_mem_request_if;
  import cpu_cache_pkg::*;
  logic                        read;
  logic                        write;
  logic [CACHE_ADDR_WIDTH-1:0] addr;
  logic [CACHE_LINE_WIDTH-1:0] data;
  modport master (output read, write, addr, data);
  modport slave  (input  read, write, addr, data);
endinterface

interface cpu_cache_mem_response_if;
  import cpu_cache_pkg::*;
  logic                        valid;
  logic [CACHE_ADDR_WIDTH-1:0] addr;
  logic [CACHE_LINE_WIDTH-1:0] data;
  modport master (output valid, addr, data);
  modport slave  (input  valid, addr, data);
endinterface

// File: rtl/cpu_cache_line_array.sv
// Line storage for cpu_cache: combinational index read, synchronous word
// write and line fill, asynchronous active-low clear of valid/dirty.
module cpu_cache_line_array
  import cpu_cache_pkg::*;
#(
  parameter int NUM_LINES = CACHE_NUM_LINES
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [INDEX_BITS-1:0]       rd_index,
  output cache_line_t                 rd_line,
  input  logic                        word_wr_en,
  input  logic [INDEX_BITS-1:0]       word_wr_index,
  input  logic [WORD_SEL_BITS-1:0]    word_wr_sel,
  input  logic [CACHE_WORD_WIDTH-1:0] word_wr_data,
  input  logic                        fill_en,
  input  logic [INDEX_BITS-1:0]       fill_index,
  input  logic [TAG_BITS-1:0]         fill_tag,
  input  logic [CACHE_LINE_WIDTH-1:0] fill_data,
  input  logic                        clean_en,
  input  logic [INDEX_BITS-1:0]       clean_index
);

  logic [NUM_LINES-1:0]                                  valid_r;
  logic [NUM_LINES-1:0]                                  dirty_r;
  logic [TAG_BITS-1:0]                                   tag_r  [NUM_LINES];
  logic [WORDS_PER_LINE-1:0][CACHE_WORD_WIDTH-1:0]       data_r [NUM_LINES];

  // Combinational read of the addressed line
  always_comb begin
    rd_line       = '0;
    rd_line.valid = valid_r[rd_index];
    rd_line.dirty = dirty_r[rd_index];
    rd_line.tag   = tag_r[rd_index];
    rd_line.data  = data_r[rd_index];
  end

  // Status bits; a fill always leaves the line clean
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (fill_en) begin
      valid_r[fill_index] <= 1'b1;
      dirty_r[fill_index] <= 1'b0;
    end else if (word_wr_en) begin
      dirty_r[word_wr_index] <= 1'b1;
    end else if (clean_en) begin
      dirty_r[clean_index] <= 1'b0;
    end else begin
      dirty_r <= dirty_r;
    end
  end

  // Tag and data payload, gated by the valid bits so no reset is needed
  always_ff @(posedge clock) begin
    if (fill_en) begin
      tag_r[fill_index]  <= fill_tag;
      data_r[fill_index] <= fill_data;
    end else if (word_wr_en) begin
      data_r[word_wr_index][word_wr_sel] <= word_wr_data;
    end
  end

endmodule

// File: rtl/cpu_cache.sv
// Direct-mapped write-back, write-allocate data cache with a miss FSM.
// Define CPU_CACHE_STATS_EN to add the hit_count/miss_count outputs.
module cpu_cache
  import cpu_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = CACHE_ADDR_WIDTH,
  parameter int WORD_WIDTH = CACHE_WORD_WIDTH,
  parameter int LINE_WIDTH = CACHE_LINE_WIDTH,
  parameter int NUM_LINES  = CACHE_NUM_LINES
) (
  input  logic                     clock,
  input  logic                     reset,
  cpu_cache_request_if.slave       cache_request_if,
  cpu_cache_response_if.master     cache_response_if,
  cpu_cache_mem_request_if.master  mem_request_if,
  cpu_cache_mem_response_if.slave  mem_response_if
`ifdef CPU_CACHE_STATS_EN
  ,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
`endif
);

  cache_state_t                         state_r;
  cache_state_t                         state_next_s;
  logic [ADDR_WIDTH-OFFSET_BITS-1:0]    miss_line_r;
  logic [ADDR_WIDTH-1:0]                req_addr_s;
  logic [ADDR_WIDTH-1:0]                miss_addr_s;
  logic [ADDR_WIDTH-1:0]                wb_addr_s;
  logic [INDEX_BITS-1:0]                rd_index_s;
  logic [WORD_WIDTH-1:0]                rd_word_s;
  logic [LINE_WIDTH-1:0]                wb_data_s;
  cache_line_t                          line_s;
  logic                                 req_active_s;
  logic                                 hit_s;
  logic                                 miss_s;
  logic                                 mem_match_s;
  logic                                 wb_done_s;
  logic                                 fill_done_s;

  assign req_addr_s   = cache_request_if.addr;
  assign req_active_s = cache_request_if.read | cache_request_if.write;
  assign miss_addr_s  = {miss_line_r, {OFFSET_BITS{1'b0}}};

  // Outside IDLE the array is steered to the latched miss line, so a CPU
  // request that changes mid-miss cannot disturb the eviction or fill.
  assign rd_index_s   = (state_r == ST_IDLE) ? addr_index(req_addr_s) : addr_index(miss_addr_s);
  assign hit_s        = (state_r == ST_IDLE) && req_active_s && line_s.valid &&
                        (line_s.tag == addr_tag(req_addr_s));
  assign miss_s       = (state_r == ST_IDLE) && req_active_s && !hit_s;
  assign wb_addr_s    = line_addr(line_s.tag, addr_index(miss_addr_s));
  assign wb_data_s    = line_s.data;
  assign rd_word_s    = line_word(line_s.data, addr_word(req_addr_s));
  assign mem_match_s  = mem_response_if.valid &&
                        (mem_response_if.addr == ((state_r == ST_WRITEBACK) ? wb_addr_s : miss_addr_s));
  assign wb_done_s    = (state_r == ST_WRITEBACK) && mem_match_s;
  assign fill_done_s  = (state_r == ST_FILL) && mem_match_s;

  cpu_cache_line_array #(
    .NUM_LINES(NUM_LINES)
  ) u_line_array (
    .clock         (clock),
    .reset         (reset),
    .rd_index      (rd_index_s),
    .rd_line       (line_s),
    .word_wr_en    (hit_s && cache_request_if.write),
    .word_wr_index (addr_index(req_addr_s)),
    .word_wr_sel   (addr_word(req_addr_s)),
    .word_wr_data  (cache_request_if.data),
    .fill_en       (fill_done_s),
    .fill_index    (addr_index(miss_addr_s)),
    .fill_tag      (addr_tag(miss_addr_s)),
    .fill_data     (mem_response_if.data),
    .clean_en      (wb_done_s),
    .clean_index   (addr_index(miss_addr_s))
  );

  // Miss FSM next-state decision
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (miss_s) begin
          if (line_s.valid && line_s.dirty) begin
            state_next_s = ST_WRITEBACK;
          end else begin
            state_next_s = ST_FILL;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WRITEBACK: begin
        if (wb_done_s) begin
          state_next_s = ST_FILL;
        end else begin
          state_next_s = ST_WRITEBACK;
        end
      end
      ST_FILL: begin
        if (fill_done_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_FILL;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // FSM state and latched miss line
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      miss_line_r <= '0;
    end else begin
      state_r <= state_next_s;
      if (miss_s) begin
        miss_line_r <= req_addr_s[ADDR_WIDTH-1:OFFSET_BITS];
      end
    end
  end

  // CPU response and memory request drive
  always_comb begin
    cache_response_if.valid = hit_s;
    if (hit_s && cache_request_if.read) begin
      cache_response_if.data = rd_word_s;
    end else begin
      cache_response_if.data = '0;
    end
    mem_request_if.read  = (state_r == ST_FILL);
    mem_request_if.write = (state_r == ST_WRITEBACK);
    case (state_r)
      ST_WRITEBACK: begin
        mem_request_if.addr = wb_addr_s;
        mem_request_if.data = wb_data_s;
      end
      ST_FILL: begin
        mem_request_if.addr = miss_addr_s;
        mem_request_if.data = '0;
      end
      default: begin
        mem_request_if.addr = '0;
        mem_request_if.data = '0;
      end
    endcase
  end

`ifdef CPU_CACHE_STATS_EN
  // Free-running hit/miss event counters, wrapping at 2^32
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
    end else begin
      if (hit_s) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_s) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cpu_cache.sv
// Directed bench for cpu_cache with a per-cycle behavioural model comparison
// plus hand-computed literal expectations.
module tb_cpu_cache;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   cmp_en = 1'b0;

  always #5 clock = ~clock;

  cpu_cache_request_if      req_if();
  cpu_cache_response_if     rsp_if();
  cpu_cache_mem_request_if  mreq_if();
  cpu_cache_mem_response_if mrsp_if();

`ifdef CPU_CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cpu_cache dut (
    .clock             (clock),
    .reset             (reset),
    .cache_request_if  (req_if),
    .cache_response_if (rsp_if),
    .mem_request_if    (mreq_if),
    .mem_response_if   (mrsp_if)
`ifdef CPU_CACHE_STATS_EN
    ,
    .hit_count         (hit_count),
    .miss_count        (miss_count)
`endif
  );

  // Behavioural model: 4 lines of {valid, dirty, tag, 128-bit data} plus a
  // pending-miss phase (0 none, 1 evicting, 2 filling) and its line address.
  bit           mv [4];
  bit           md [4];
  int unsigned  mt [4];
  bit [127:0]   mdat [4];
  int           mode;
  bit [31:0]    m_line;

  localparam bit [127:0] L0     = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam bit [127:0] L0_WB  = 128'hDDDDDDDD_CCCCCCCC_12345678_AAAAAAAA;
  localparam bit [127:0] L40    = 128'h44444444_33333333_22222222_11111111;
  localparam bit [127:0] JUNK   = 128'hEEEEEEEE_EEEEEEEE_EEEEEEEE_EEEEEEEE;

  function automatic int unsigned f_idx(input bit [31:0] a);
    return (a >> 4) % 4;
  endfunction
  function automatic int unsigned f_tag(input bit [31:0] a);
    return a >> 6;
  endfunction
  function automatic int unsigned f_word(input bit [31:0] a);
    return (a >> 2) % 4;
  endfunction
  function automatic bit [31:0] f_victim_addr(input int unsigned i);
    return (mt[i] << 6) | (i << 4);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0;
      md[i] = 1'b0;
    end
    mode = 0;
  endtask

  function automatic bit model_hit();
    int unsigned i;
    i = f_idx(req_if.addr);
    return (mode == 0) && (req_if.read || req_if.write) && mv[i] && (mt[i] == f_tag(req_if.addr));
  endfunction

  // Advance the model with the inputs seen at each rising edge
  always @(posedge clock) begin
    if (reset) begin
      if (mode == 0) begin
        if (req_if.read || req_if.write) begin
          if (model_hit()) begin
            if (req_if.write) begin
              mdat[f_idx(req_if.addr)][32*f_word(req_if.addr) +: 32] = req_if.data;
              md[f_idx(req_if.addr)] = 1'b1;
            end
          end else begin
            m_line = req_if.addr & 32'hFFFF_FFF0;
            mode   = (mv[f_idx(m_line)] && md[f_idx(m_line)]) ? 1 : 2;
          end
        end
      end else if (mode == 1) begin
        if (mrsp_if.valid && mrsp_if.addr == f_victim_addr(f_idx(m_line))) begin
          md[f_idx(m_line)] = 1'b0;
          mode = 2;
        end
      end else begin
        if (mrsp_if.valid && mrsp_if.addr == m_line) begin
          mdat[f_idx(m_line)] = mrsp_if.data;
          mv[f_idx(m_line)]   = 1'b1;
          md[f_idx(m_line)]   = 1'b0;
          mt[f_idx(m_line)]   = f_tag(m_line);
          mode = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Compare every DUT output against the model on each falling edge
  always @(negedge clock) begin
    bit          hit;
    bit [31:0]   exp_data;
    bit [31:0]   exp_addr;
    bit [127:0]  exp_line;
    if (cmp_en) begin
      hit      = model_hit();
      exp_data = (hit && req_if.read) ? mdat[f_idx(req_if.addr)][32*f_word(req_if.addr) +: 32] : 32'd0;
      exp_addr = (mode == 2) ? m_line : (mode == 1) ? f_victim_addr(f_idx(m_line)) : 32'd0;
      exp_line = (mode == 1) ? mdat[f_idx(m_line)] : 128'd0;
      check("model_rsp_valid", rsp_if.valid, hit);
      check("model_rsp_data",  rsp_if.data,  exp_data);
      check("model_mem_read",  mreq_if.read, mode == 2);
      check("model_mem_write", mreq_if.write, mode == 1);
      check("model_mem_addr",  mreq_if.addr, exp_addr);
      check("model_mem_data",  mreq_if.data, exp_line);
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic cpu(input bit rd, input bit wr, input bit [31:0] a, input bit [31:0] d);
    req_if.read  = rd;
    req_if.write = wr;
    req_if.addr  = a;
    req_if.data  = d;
  endtask

  task automatic mem(input bit v, input bit [31:0] a, input bit [127:0] d);
    mrsp_if.valid = v;
    mrsp_if.addr  = a;
    mrsp_if.data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    cpu(1'b0, 1'b0, 32'h0, 32'h0);
    mem(1'b0, 32'h0, 128'h0);
    model_reset();
    tick();
    tick();
    #1;
    check("reset_rsp_valid", rsp_if.valid, 1'b0);
    check("reset_mem_read",  mreq_if.read, 1'b0);
    check("reset_mem_write", mreq_if.write, 1'b0);
    reset  = 1'b1;
    cmp_en = 1'b1;

    cpu(1'b1, 1'b0, 32'h0, 32'h0);
    #1 check("cold_miss_valid", rsp_if.valid, 1'b0);
    check("cold_miss_memrd", mreq_if.read, 1'b0);
    tick(); #1;
    check("fill0_read", mreq_if.read, 1'b1);
    check("fill0_addr", mreq_if.addr, 32'h0);
    mem(1'b1, 32'h0, L0);
    tick(); mem(1'b0, 32'h0, 128'h0); #1;
    check("fill0_hit_valid", rsp_if.valid, 1'b1);
    check("fill0_hit_data",  rsp_if.data, 32'hAAAAAAAA);
    check("fill0_memrd_off", mreq_if.read, 1'b0);

    tick(); cpu(1'b1, 1'b0, 32'h4, 32'h0); #1 check("rd4",  rsp_if.data, 32'hBBBBBBBB);
    tick(); cpu(1'b1, 1'b0, 32'h8, 32'h0); #1 check("rd8",  rsp_if.data, 32'hCCCCCCCC);
    tick(); cpu(1'b1, 1'b0, 32'hC, 32'h0); #1 check("rdC",  rsp_if.data, 32'hDDDDDDDD);
    check("rdC_valid", rsp_if.valid, 1'b1);
    check("rdC_no_mem", {mreq_if.read, mreq_if.write}, 2'b00);

    tick(); cpu(1'b0, 1'b1, 32'h4, 32'h12345678); #1 check("wr4_valid", rsp_if.valid, 1'b1);
    tick(); cpu(1'b1, 1'b0, 32'h4, 32'h0); #1 check("rd4_after_wr", rsp_if.data, 32'h12345678);

    tick(); cpu(1'b1, 1'b0, 32'h40, 32'h0); #1;
    check("conflict_miss_valid", rsp_if.valid, 1'b0);
    check("conflict_miss_nowr", mreq_if.write, 1'b0);
    tick(); #1;
    check("wb_write", mreq_if.write, 1'b1);
    check("wb_addr",  mreq_if.addr, 32'h0);
    check("wb_data",  mreq_if.data, L0_WB);
    mem(1'b1, 32'h0, 128'h0);
    tick(); mem(1'b0, 32'h0, 128'h0); #1;
    check("fill40_read", mreq_if.read, 1'b1);
    check("fill40_addr", mreq_if.addr, 32'h40);
    check("fill40_nowr", mreq_if.write, 1'b0);
    mem(1'b1, 32'h40, L40);
    tick(); mem(1'b0, 32'h0, 128'h0); #1;
    check("fill40_hit", rsp_if.data, 32'h11111111);

    // Victim is now clean: straight to FILL; a wrong-address response is ignored
    tick(); cpu(1'b1, 1'b0, 32'h0, 32'h0); #1 check("refill_miss", rsp_if.valid, 1'b0);
    tick(); #1;
    check("clean_victim_no_wb", mreq_if.write, 1'b0);
    check("refill_read", mreq_if.read, 1'b1);
    mem(1'b1, 32'h80, JUNK);
    tick(); mem(1'b0, 32'h0, 128'h0); #1;
    check("wrong_addr_ignored", mreq_if.read, 1'b1);
    check("wrong_addr_hold",    mreq_if.addr, 32'h0);
    mem(1'b1, 32'h0, L0_WB);
    tick(); mem(1'b0, 32'h0, 128'h0); #1;
    check("refill_hit", rsp_if.data, 32'hAAAAAAAA);
    tick(); cpu(1'b1, 1'b0, 32'h4, 32'h0); #1 check("refill_wb_word", rsp_if.data, 32'h12345678);

    // Reset in the middle of a fill abandons it
    tick(); cpu(1'b1, 1'b0, 32'h14, 32'h0);
    tick(); #1 check("fill14_addr", mreq_if.addr, 32'h10);
    reset = 1'b0;
    model_reset();
    #1;
    check("rst_rsp_valid", rsp_if.valid, 1'b0);
    check("rst_rsp_data",  rsp_if.data, 32'h0);
    check("rst_mem_rdwr",  {mreq_if.read, mreq_if.write}, 2'b00);
    check("rst_mem_addr",  mreq_if.addr, 32'h0);
    check("rst_mem_data",  mreq_if.data, 128'h0);
    tick(); reset = 1'b1; cpu(1'b1, 1'b0, 32'h0, 32'h0); #1;
    check("post_reset_miss", rsp_if.valid, 1'b0);
    tick(); #1;
    check("post_reset_fill", mreq_if.read, 1'b1);
    check("post_reset_nowb", mreq_if.write, 1'b0);
    mem(1'b1, 32'h0, L0_WB);
    tick(); mem(1'b0, 32'h0, 128'h0); #1;
    check("post_reset_hit", rsp_if.data, 32'hAAAAAAAA);

    tick(); cpu(1'b0, 1'b0, 32'h0, 32'h0); #1;
    check("idle_no_valid", rsp_if.valid, 1'b0);
    check("idle_no_data",  rsp_if.data, 32'h0);
    tick();
    tick();
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
